uart_tx_feeder: RTL and testbench
=================================

Name: uart_tx_feeder

Overview:
- Byte FIFO plus send sequencer between the USB3300 sniffer capture logic and the UART transmitter.
- Absorbs bursts of captured bytes and releases them one at a time.
- Drives the UART's I_DATA/send_data inputs.
- Paces releases by the UART's TiP (transmission-in-progress) flag, so no byte is lost while a frame is on the line.

Parameters:
- DEPTH, 16, FIFO entries; power of two, minimum 2.
- START_TIMEOUT, 15, cycles to wait for TiP to rise after a send pulse before re-issuing the same byte; must be ≥4.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous reset, active-low.
- wr_data  in  8  byte from the capture logic.
- wr_en  in  1  push wr_data this cycle.
- full  out  1  FIFO holds DEPTH entries.
- empty  out  1  FIFO holds 0 entries.
- level  out  $clog2(DEPTH)+1  current FIFO occupancy.
- tx_tip  in  1  UART TiP.
- tx_data  out  8  to UART I_DATA.
- tx_send  out  1  to UART send_data; one-cycle pulse.
- busy  out  1  sequencer not IDLE.

Behaviour:
- Reset: clk edge with rst_n=0 gives:
  - FIFO pointers and level = 0; empty=1, full=0.
  - tx_data=8'h00, tx_send=0, busy=0, state=IDLE.
  - Reset mid-frame aborts sequencing only. The UART frame already on the line completes on its own (the UART has no reset). After reset the sequencer waits for tx_tip=0 before issuing any send.
- FIFO:
  - Circular buffer, pointers $clog2(DEPTH) bits wide, wrap modulo DEPTH. level tracks occupancy in the extra bit.
  - A push when full is dropped. The dropped byte is not stored and pointers are unchanged, even if a pop happens in the same cycle.
  - Simultaneous push and pop when not full: level unchanged, both pointers advance.
  - Pop only occurs internally, on the IDLE→SEND transition.
- Sequencer states:
  - IDLE:
    - busy=0.
    - If !empty && !tx_tip: tx_data <= head, pop, go SEND.
    - Otherwise stay.
  - SEND:
    - tx_send=1 for exactly this one cycle; tx_data held.
    - Go WAIT_START; clear the timeout counter.
  - WAIT_START:
    - If tx_tip=1, go WAIT_DONE.
    - Else if the counter reaches START_TIMEOUT, go SEND, re-issuing the same tx_data with no new pop.
    - Else increment the counter.
  - WAIT_DONE:
    - tx_data held stable.
    - If tx_tip=0, go IDLE.
- Latency:
  - wr_en=1 at edge 0 into an empty FIFO with tx_tip=0: tx_send=1 in the cycle after edge 1.
  - tx_data is valid from that same cycle until return to IDLE.
- Expected UART response: tx_tip rises 2 cycles after tx_send. Back-to-back bytes are separated by ≥1 IDLE cycle after tx_tip falls.
- tx_send is never asserted while tx_tip=1.

Optional Feature:
- Macro UART_TX_FEEDER_STATS_EN.
- When defined:
  - Adds output drop_cnt (16 bits). It increments on every push dropped due to full and saturates at 16'hFFFF.
  - Adds output retry_cnt (8 bits). It increments on every WAIT_START timeout and saturates at 8'hFF.
  - Both counters reset to 0 by rst_n.
- When undefined: neither port nor any counter logic exists; behaviour is otherwise identical.

Decomposition:
- Shared package/header uart_pkg:
  - Sequencer state encodings: IDLE=2'b00, SEND=2'b01, WAIT_START=2'b10, WAIT_DONE=2'b11.
  - Byte width constant (8).
- One natural sub-module: sync_fifo. This is the parameterised circular buffer with full/empty/level and drop-on-full. uart_tx_feeder instantiates it and contains only the sequencer and optional counters.

Test Plan:
- Single byte:
  - Stimulus: reset, push 8'hA5; UART model raises tip 2 cycles after send and holds it 20 cycles.
  - Required: tx_send high exactly 1 cycle, 2 cycles after push, with tx_data=8'hA5; busy drops 1 cycle after tip falls; empty=1.
- Burst/order:
  - Stimulus: push 8'h01..8'h10 on consecutive cycles, DEPTH=16.
  - Required: full=1 after the 16th push; bytes emerge in order 01..10; no tx_send while tip=1.
- Overflow:
  - Stimulus: with tip held high, push 20 bytes.
  - Required: level=16; bytes 17–20 dropped; with STATS_EN, drop_cnt=4.
- Timeout retry:
  - Stimulus: UART model ignores the first send pulse.
  - Required: second tx_send 16 cycles after SEND (START_TIMEOUT=15) with the same tx_data; level not decremented twice; retry_cnt=1.
- Reset mid-frame:
  - Stimulus: rst_n=0 for 1 cycle while in WAIT_DONE with 5 bytes queued and tip=1.
  - Required: level=0, tx_send=0; no send until tip falls; a later push of 8'h3C is sent normally.
- Wrap-around:
  - Stimulus: 40 push/drain cycles interleaved, with simultaneous push while popping.
  - Required: level consistent every cycle; output byte sequence equals input sequence.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit feeder: byte width and sequencer state encoding.
// No logic here; imported by the FIFO and the sequencer.
// Neither latency nor backpressure applies to this file.
package uart_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE       = 2'b00,
    SEND       = 2'b01,
    WAIT_START = 2'b10,
    WAIT_DONE  = 2'b11
  } seq_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Circular byte buffer with occupancy level; the head entry is visible combinationally on rd_data.
// Latency: a push is visible at the head one clock later; a pop advances the head on the same edge.
// Backpressure: a push while full is dropped with pointers untouched, even if a pop happens that cycle.
module sync_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int W     = BYTE_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [W-1:0]             wr_data,
  input  logic                     wr_en,
  input  logic                     rd_en,
  output logic [W-1:0]             rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (level == FULL_LVL);
  assign empty   = (level == '0);
  assign push_ok = wr_en && !full;
  assign pop_ok  = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  // Storage is left unreset; only the pointers and level define valid contents.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_feeder.sv
// Byte FIFO plus send sequencer feeding a UART, paced by its TiP flag; UART_TX_FEEDER_STATS_EN adds drop/retry counters.
// Latency: a byte pushed into an idle, empty feeder produces tx_send in the cycle after the next edge.
// Backpressure: pushes while full are dropped; sends wait for tx_tip low and are re-issued if TiP never rises.
module uart_tx_feeder
  import uart_pkg::*;
#(
  parameter int DEPTH         = 16,
  parameter int START_TIMEOUT = 15
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [7:0]               wr_data,
  input  logic                     wr_en,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level,
  input  logic                     tx_tip,
  output logic [7:0]               tx_data,
  output logic                     tx_send,
  output logic                     busy
`ifdef UART_TX_FEEDER_STATS_EN
  ,
  output logic [15:0]              drop_cnt,
  output logic [7:0]               retry_cnt
`endif
);

  localparam int CW = $clog2(START_TIMEOUT + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(START_TIMEOUT - 1);

  seq_state_t    state;
  seq_state_t    state_nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic [7:0]    tx_data_nxt;
  logic [7:0]    head;
  logic          pop;

  sync_fifo #(
    .DEPTH (DEPTH),
    .W     (BYTE_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_data (wr_data),
    .wr_en   (wr_en),
    .rd_en   (pop),
    .rd_data (head),
    .full    (full),
    .empty   (empty),
    .level   (level)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      tx_data <= 8'h00;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      tx_data <= tx_data_nxt;
    end
  end

  // WAIT_START lasts START_TIMEOUT cycles before the same byte is re-sent.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    tx_data_nxt = tx_data;
    pop         = 1'b0;
    case (state)
      IDLE: begin
        if (!empty && !tx_tip) begin
          tx_data_nxt = head;
          pop         = 1'b1;
          state_nxt   = SEND;
        end
      end
      SEND: begin
        state_nxt = WAIT_START;
        cnt_nxt   = '0;
      end
      WAIT_START: begin
        if (tx_tip)              state_nxt = WAIT_DONE;
        else if (cnt == TO_LAST) state_nxt = SEND;
        else                     cnt_nxt   = cnt + 1'b1;
      end
      WAIT_DONE: begin
        if (!tx_tip) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign tx_send = (state == SEND);
  assign busy    = (state != IDLE);

`ifdef UART_TX_FEEDER_STATS_EN
  logic drop;
  logic retry;

  assign drop  = wr_en && full;
  assign retry = (state == WAIT_START) && !tx_tip && (cnt == TO_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      drop_cnt  <= '0;
      retry_cnt <= '0;
    end else begin
      if (drop && (drop_cnt != 16'hFFFF))  drop_cnt  <= drop_cnt + 1'b1;
      if (retry && (retry_cnt != 8'hFF))   retry_cnt <= retry_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Bench for uart_tx_feeder: queue-based reference model plus a simple UART TiP responder.
// Build with +define+UART_TX_FEEDER_STATS_EN to also check the drop/retry counters.
module tb_uart_tx_feeder;

  localparam int DEPTH         = 16;
  localparam int START_TIMEOUT = 15;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       wr_en = 1'b0;
  logic       full, empty, tx_send, busy, tx_tip;
  logic [4:0] level;
  logic [7:0] tx_data;
`ifdef UART_TX_FEEDER_STATS_EN
  logic [15:0] drop_cnt;
  logic [7:0]  retry_cnt;
`endif

  logic uart_tip  = 1'b0;
  logic tip_force = 1'b0;
  assign tx_tip = uart_tip | tip_force;

  uart_tx_feeder #(.DEPTH(DEPTH), .START_TIMEOUT(START_TIMEOUT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_data   (wr_data),
    .wr_en     (wr_en),
    .full      (full),
    .empty     (empty),
    .level     (level),
    .tx_tip    (tx_tip),
    .tx_data   (tx_data),
    .tx_send   (tx_send),
    .busy      (busy)
`ifdef UART_TX_FEEDER_STATS_EN
    ,
    .drop_cnt  (drop_cnt),
    .retry_cnt (retry_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference model state
  logic [7:0] exp_q[$];
  int         m_level = 0;
  bit         awaiting = 0;
  logic [7:0] last_byte = 8'h00;
  int         n_sent = 0, n_acc = 0, n_drops = 0, n_retries = 0, n_simul = 0;

  // UART responder state
  int rise_cnt = 0, hold_cnt = 0, hold_len = 20, tip_fall_cyc = -1;
  bit ignore_next = 0;

  // One clock: model update, UART response, and per-cycle scoreboard checks.
  task automatic step();
    bit was_rst, push_acc, popped, tip_now;
    @(posedge clk);
    was_rst  = !rst_n;
    push_acc = rst_n && wr_en && (m_level < DEPTH);
    if (rst_n && wr_en && (m_level == DEPTH)) n_drops++;
    #1;
    cyc++;
    popped = 0;
    if (was_rst) begin
      exp_q.delete();
      m_level = 0; awaiting = 0; n_drops = 0; n_retries = 0;
    end else begin
      if (push_acc) begin
        exp_q.push_back(wr_data);
        m_level++; n_acc++;
      end
      if (tx_send) begin
        checks++;
        if (awaiting) begin
          n_retries++;
          if (tx_data !== last_byte) begin
            errors++;
            $display("FAIL retry_data: got %02h expected %02h at cycle %0d", tx_data, last_byte, cyc);
          end
        end else if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_send: got tx_send=1 expected no send (queue empty) at cycle %0d", cyc);
        end else begin
          last_byte = exp_q.pop_front();
          m_level--; n_sent++; popped = 1;
          if (tx_data !== last_byte) begin
            errors++;
            $display("FAIL send_order: got %02h expected %02h at cycle %0d", tx_data, last_byte, cyc);
          end
        end
        awaiting = 1;
      end
    end
    if (push_acc && popped) n_simul++;

    if (rise_cnt > 0) begin
      rise_cnt--;
      if (rise_cnt == 0) begin uart_tip = 1'b1; hold_cnt = hold_len; end
    end else if (uart_tip) begin
      hold_cnt--;
      if (hold_cnt == 0) begin uart_tip = 1'b0; tip_fall_cyc = cyc; end
    end
    if (tx_send) begin
      if (ignore_next) ignore_next = 0;
      else rise_cnt = 2;
    end
    tip_now = uart_tip | tip_force;
    if (tip_now) awaiting = 0;

    checks++;
    if (tx_send && tip_now) begin
      errors++;
      $display("FAIL send_during_tip: got tx_send=1 with tip=1 expected no send at cycle %0d", cyc);
    end
    checks++;
    if (level !== 5'(m_level)) begin
      errors++;
      $display("FAIL level: got %0d expected %0d at cycle %0d", level, m_level, cyc);
    end
    checks++;
    if (empty !== (m_level == 0) || full !== (m_level == DEPTH)) begin
      errors++;
      $display("FAIL flags: got empty=%0b full=%0b expected level %0d at cycle %0d", empty, full, m_level, cyc);
    end
`ifdef UART_TX_FEEDER_STATS_EN
    checks++;
    if (drop_cnt !== 16'(n_drops) || retry_cnt !== 8'(n_retries)) begin
      errors++;
      $display("FAIL stats: got drop=%0d retry=%0d expected drop=%0d retry=%0d", drop_cnt, retry_cnt, n_drops, n_retries);
    end
`endif
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || busy || uart_tip || rise_cnt != 0) && n < 3000) begin
      step();
      n++;
    end
    checks++;
    if (n >= 3000) begin
      errors++;
      $display("FAIL drain_timeout: got %0d bytes pending expected 0", exp_q.size());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step(); step();
    rst_n = 1'b1;
    checks++;
    if (level !== 5'd0 || empty !== 1'b1 || full !== 1'b0) begin
      errors++;
      $display("FAIL reset_fifo: got level=%0d empty=%0b full=%0b expected 0/1/0", level, empty, full);
    end
    checks++;
    if (tx_data !== 8'h00 || tx_send !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_seq: got data=%02h send=%0b busy=%0b expected 00/0/0", tx_data, tx_send, busy);
    end
  endtask

  task automatic test_single_byte();
    int busy_fall = -1;
    hold_len = 20;
    wr_data = 8'hA5; wr_en = 1'b1;
    step();
    wr_en = 1'b0;
    checks++;
    if (tx_send !== 1'b0) begin
      errors++; $display("FAIL single_early: got tx_send=%0b expected 0", tx_send);
    end
    step();
    checks++;
    if (tx_send !== 1'b1 || tx_data !== 8'hA5) begin
      errors++; $display("FAIL single_send: got send=%0b data=%02h expected 1/a5", tx_send, tx_data);
    end
    step();
    checks++;
    if (tx_send !== 1'b0) begin
      errors++; $display("FAIL single_pulse_width: got tx_send=%0b expected 0", tx_send);
    end
    for (int i = 0; i < 60 && busy_fall < 0; i++) begin
      step();
      if (!busy) busy_fall = cyc;
    end
    checks++;
    if (busy_fall - tip_fall_cyc != 1) begin
      errors++; $display("FAIL single_busy_drop: got %0d cycles after tip fall expected 1", busy_fall - tip_fall_cyc);
    end
    checks++;
    if (empty !== 1'b1) begin
      errors++; $display("FAIL single_empty: got %0b expected 1", empty);
    end
  endtask

  task automatic test_burst();
    int sent0 = n_sent;
    tip_force = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      wr_data = 8'(i); wr_en = 1'b1;
      step();
    end
    wr_en = 1'b0;
    checks++;
    if (full !== 1'b1 || level !== 5'd16) begin
      errors++; $display("FAIL burst_full: got full=%0b level=%0d expected 1/16", full, level);
    end
    tip_force = 1'b0;
    drain();
    checks++;
    if (n_sent - sent0 != 16) begin
      errors++; $display("FAIL burst_count: got %0d bytes expected 16", n_sent - sent0);
    end
  endtask

  task automatic test_overflow();
    int sent0 = n_sent;
`ifdef UART_TX_FEEDER_STATS_EN
    logic [15:0] d0 = drop_cnt;
`endif
    tip_force = 1'b1;
    for (int i = 0; i < 20; i++) begin
      wr_data = 8'($urandom); wr_en = 1'b1;
      step();
    end
    wr_en = 1'b0;
    checks++;
    if (level !== 5'd16 || full !== 1'b1) begin
      errors++; $display("FAIL overflow_level: got %0d expected 16", level);
    end
`ifdef UART_TX_FEEDER_STATS_EN
    checks++;
    if (drop_cnt - d0 !== 16'd4) begin
      errors++; $display("FAIL overflow_drops: got %0d expected 4", drop_cnt - d0);
    end
`endif
    tip_force = 1'b0;
    drain();
    checks++;
    if (n_sent - sent0 != 16) begin
      errors++; $display("FAIL overflow_count: got %0d bytes expected 16", n_sent - sent0);
    end
  endtask

  task automatic test_timeout();
    int         scyc[$];
    logic [7:0] sdat[$];
    logic [7:0] b0 = 8'($urandom);
    logic [7:0] b1 = 8'($urandom);
    int         lvl_at_retry = -1;
`ifdef UART_TX_FEEDER_STATS_EN
    logic [7:0] r0 = retry_cnt;
`endif
    hold_len = 10;
    ignore_next = 1;
    for (int i = 0; i < 60 && scyc.size() < 2; i++) begin
      wr_en   = (i < 2);
      wr_data = (i == 0) ? b0 : b1;
      step();
      if (tx_send) begin
        scyc.push_back(cyc);
        sdat.push_back(tx_data);
        if (scyc.size() == 2) lvl_at_retry = int'(level);
      end
    end
    wr_en = 1'b0;
    checks++;
    if (scyc.size() != 2) begin
      errors++; $display("FAIL timeout_sends: got %0d sends expected 2", scyc.size());
    end else begin
      checks++;
      if (scyc[1] - scyc[0] != 16) begin
        errors++; $display("FAIL timeout_gap: got %0d cycles expected 16", scyc[1] - scyc[0]);
      end
      checks++;
      if (sdat[0] !== b0 || sdat[1] !== b0) begin
        errors++; $display("FAIL timeout_data: got %02h,%02h expected %02h", sdat[0], sdat[1], b0);
      end
      checks++;
      if (lvl_at_retry != 1) begin
        errors++; $display("FAIL timeout_level: got %0d expected 1", lvl_at_retry);
      end
    end
`ifdef UART_TX_FEEDER_STATS_EN
    checks++;
    if (retry_cnt - r0 !== 8'd1) begin
      errors++; $display("FAIL timeout_retry_cnt: got %0d expected 1", retry_cnt - r0);
    end
`endif
    drain();
  endtask

  task automatic test_reset_midframe();
    int sent0;
    hold_len = 20;
    for (int i = 0; i < 6; i++) begin
      wr_data = 8'($urandom); wr_en = 1'b1;
      step();
    end
    wr_en = 1'b0;
    for (int i = 0; i < 10 && !uart_tip; i++) step();
    checks++;
    if (!uart_tip || busy !== 1'b1 || level !== 5'd5) begin
      errors++; $display("FAIL midframe_setup: got tip=%0b busy=%0b level=%0d expected 1/1/5", uart_tip, busy, level);
    end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    checks++;
    if (level !== 5'd0 || tx_send !== 1'b0 || busy !== 1'b0 || tx_data !== 8'h00) begin
      errors++; $display("FAIL midframe_reset: got level=%0d send=%0b busy=%0b data=%02h expected 0/0/0/00", level, tx_send, busy, tx_data);
    end
    sent0 = n_sent;
    wr_data = 8'h3C; wr_en = 1'b1;
    step();
    wr_en = 1'b0;
    for (int i = 0; i < 40 && uart_tip; i++) begin
      step();
      checks++;
      if (tx_send !== 1'b0) begin
        errors++; $display("FAIL midframe_wait: got tx_send=1 expected 0 while tip high");
      end
    end
    drain();
    checks++;
    if (n_sent - sent0 != 1 || last_byte !== 8'h3C) begin
      errors++; $display("FAIL midframe_after: got %0d sends last=%02h expected 1/3c", n_sent - sent0, last_byte);
    end
  endtask

  task automatic test_wrap();
    int sent0 = n_sent;
    int acc0  = n_acc;
    int sim0  = n_simul;
    hold_len = 2;
    for (int r = 0; r < 40; r++) begin
      for (int i = 0; i < int'($urandom_range(1, 4)); i++) begin
        wr_data = 8'($urandom); wr_en = 1'b1;
        step();
      end
      wr_en = 1'b0;
      for (int i = 0; i < int'($urandom_range(0, 8)); i++) step();
    end
    drain();
    checks++;
    if (n_sent - sent0 != n_acc - acc0) begin
      errors++; $display("FAIL wrap_count: got %0d sent expected %0d", n_sent - sent0, n_acc - acc0);
    end
    checks++;
    if (n_simul - sim0 == 0) begin
      errors++; $display("FAIL wrap_simul: got 0 simultaneous push/pop expected at least 1");
    end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_burst();
    test_overflow();
    test_timeout();
    test_reset_midframe();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
